tp_mem_fifo_ctrl_16384_32: RTL and testbench
============================================

Name: tp_mem_fifo_ctrl_16384_32

Overview:
- Single-clock FIFO controller that drives an externally instantiated tp_mem_2r2w_16384_32 as its storage.
- Port A is the write port; port B is the read port, with its wen_b tied low.
- Upstream sees a valid/ready write stream and downstream sees a valid/ready read stream.
- A 2-entry output skid buffer hides the memory's 1-cycle read latency, so throughput is 1 word/cycle.

Parameters:
DEPTH, 16384, number of memory words (power of two)
ADDR_W, 14, log2(DEPTH), width of the memory address
DATA_W, 32, data word width
CNT_W, 15, width of count; must hold DEPTH+2

Ports:
clk  in  1  single clock; memory clk_a and clk_b are tied to it
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream word valid
in_ready  out  1  controller can accept a word
in_data  in  DATA_W  upstream word
out_valid  out  1  head word available
out_ready  in  1  downstream accepts head word
out_data  out  DATA_W  head word
count  out  CNT_W  words held (memory + in-flight + skid buffer)
mem_wen_a  out  1  to memory wen_a
mem_addr_a  out  ADDR_W  to memory addr_a (write pointer)
mem_data_in_a  out  DATA_W  to memory data_in_a
mem_addr_b  out  ADDR_W  to memory addr_b (read pointer)
mem_data_out_b  in  DATA_W  from memory data_out_b, valid 1 cycle after read issue

Behaviour:
Reset values:
- in_ready=0 while rst is high, 1 after release.
- out_valid=0, count=0, mem_wen_a=0.
- Both pointers, mem_cnt, inflight and skid occupancy are 0.
- Memory contents are not cleared.

Write side:
- push = in_valid & in_ready.
- in_ready = (mem_cnt != DEPTH); it is registered-state based only and ignores a same-cycle read.
- On push: mem_wen_a=1, mem_addr_a=wr_ptr, mem_data_in_a=in_data. On the next clk edge wr_ptr increments mod DEPTH.

Read issue:
- pop = out_valid & out_ready.
- issue = (mem_cnt > 0) & (2 - skid_occ - inflight + pop >= 1).
- mem_addr_b is always driven from rd_ptr. When issue is high, rd_ptr increments mod DEPTH at the edge and inflight is set to 1; otherwise inflight is cleared to 0.
- mem_cnt next value = mem_cnt + push - issue.
- A pushed word is only readable from the cycle after its write, so there is no same-address read/write hazard on ports A/B.

Skid buffer:
- It is a 2-entry FIFO.
- Its write enable is the registered inflight flag, and its write data is mem_data_out_b.
- out_valid = skid_occ != 0; out_data = skid head.
- A same-cycle capture and pop is allowed at any occupancy.
- Capture into a full buffer is impossible by the credit rule; an assertion in the RTL checks this.

Latency:
- A word pushed at edge t0 into an empty controller is read-issued during cycle t0..t1.
- It appears with out_valid=1 after edge t0+2, so the latency is 2 cycles.

Count and capacity:
- count = mem_cnt + inflight + skid_occ; maximum DEPTH+2.
- Maximum capacity is DEPTH+2 words: DEPTH in memory plus 2 in the skid buffer.

Boundary conditions:
- Full: mem_cnt=DEPTH forces in_ready=0. A pop that cycle does not raise in_ready until the following issue reduces mem_cnt.
- Empty: out_valid=0 and out_data holds its last value. out_ready is ignored.
- Pointer wrap: DEPTH-1 goes to 0 with no gap or bubble.
- Push and pop together at steady state: count is unchanged.
- Reset mid-operation: all held words are discarded and the state returns to reset values asynchronously. The first push after release lands at address 0.

Decomposition:
- Shared package: DATA_W/ADDR_W/DEPTH/CNT_W constants, plus a localparam for skid depth (SKID_DEPTH=2).
- One sub-module: tp_fifo2_skid, a 2-entry register FIFO with wr_en, wr_data, rd_en, rd_data, occupancy, and async active-high reset.
- The top level holds pointers, mem_cnt, inflight and the issue logic. Memory is instantiated by the parent and is not inside this block.

Test Plan:
- Single word: push 0xDEADBEEF at edge t0 with out_ready=1 → mem_wen_a=1 with addr 0 at t0; out_valid=1 with data 0xDEADBEEF after t0+2; count goes 1,1,1,0.
- Fill: push 16386 words with out_ready=0 → in_ready=0 once mem_cnt=16384; count=16386. Then drain and check 16386 words in order.
- Streaming: continuous push and pop of an incrementing pattern for 1000 cycles → after 2-cycle fill, 1 word/cycle in order; count steady at 2 or 3; no in_ready drop.
- Backpressure: random out_ready at 30% duty during continuous push → no loss or duplication, and out_data stays stable while out_valid & !out_ready.
- Wrap: push/pop 40000 words with periodic stalls → mem_addr_a and mem_addr_b wrap from 16383 to 0; data order preserved.
- Reset mid-burst: assert rst with count=500 → out_valid=0, count=0 immediately; after release, the next push writes addr 0 and is read back 2 cycles later.

Source files
------------

// File: rtl/tp_mem_fifo_ctrl_16384_32_pkg.sv
// Shared constants and the read-credit rule for the tp_mem_2r2w_16384_32 FIFO controller.
package tp_mem_fifo_ctrl_16384_32_pkg;

   localparam int DEPTH      = 16384;
   localparam int ADDR_W     = 14;
   localparam int DATA_W     = 32;
   localparam int CNT_W      = 15;
   localparam int SKID_DEPTH = 2;
   localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

   // A read may be issued only if a skid slot is guaranteed free when its data lands.
   function automatic logic can_issue(input logic [OCC_W-1:0] occ,
                                      input logic             inflight,
                                      input logic             pop);
      int signed credit;
      credit = SKID_DEPTH - int'(occ) - int'(inflight) + int'(pop);
      return credit >= 1;
   endfunction

endpackage

// File: rtl/tp_fifo2_skid.sv
// Two-entry register FIFO that absorbs the memory read latency; head is always in head_q.
module tp_fifo2_skid
   import tp_mem_fifo_ctrl_16384_32_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic [OCC_W-1:0]  occupancy
);

   logic [DATA_W-1:0] head_q;
   logic [DATA_W-1:0] tail_q;
   logic [OCC_W-1:0]  occ_q;
   logic              rd_eff;

   assign rd_eff    = rd_en && (occ_q != '0);
   assign rd_data   = head_q;
   assign occupancy = occ_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_q + OCC_W'(wr_en) - OCC_W'(rd_eff);
      end
   end

   // Head holds its last value once the buffer empties.
   always_ff @(posedge clk) begin
      case (occ_q)
         2'd0: begin
            if (wr_en) head_q <= wr_data;
         end
         2'd1: begin
            if (wr_en && rd_eff) head_q <= wr_data;
            else if (wr_en)      tail_q <= wr_data;
         end
         default: begin
            if (rd_eff) begin
               head_q <= tail_q;
               if (wr_en) tail_q <= wr_data;
            end
         end
      endcase
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(wr_en && (occ_q == OCC_W'(SKID_DEPTH)) && !rd_en));

endmodule

// File: rtl/tp_mem_fifo_ctrl_16384_32.sv
// FIFO controller: write/read pointers and read-issue credit around an external 2r2w memory.
module tp_mem_fifo_ctrl_16384_32
   import tp_mem_fifo_ctrl_16384_32_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  count,
   output logic              mem_wen_a,
   output logic [ADDR_W-1:0] mem_addr_a,
   output logic [DATA_W-1:0] mem_data_in_a,
   output logic [ADDR_W-1:0] mem_addr_b,
   input  logic [DATA_W-1:0] mem_data_out_b
);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  mem_cnt;
   logic              inflight;
   logic [OCC_W-1:0]  skid_occ;
   logic              push;
   logic              pop;
   logic              issue;

   assign in_ready  = !rst && (mem_cnt != CNT_W'(DEPTH));
   assign push      = in_valid && in_ready;
   assign out_valid = (skid_occ != '0);
   assign pop       = out_valid && out_ready;
   assign issue     = (mem_cnt != '0) && can_issue(skid_occ, inflight, pop);

   assign mem_wen_a     = push;
   assign mem_addr_a    = wr_ptr;
   assign mem_data_in_a = in_data;
   assign mem_addr_b    = rd_ptr;

   assign count = mem_cnt + CNT_W'(inflight) + CNT_W'(skid_occ);

   // Issue stage: inflight marks data arriving from the memory next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         inflight <= 1'b0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + ADDR_W'(1);
         if (issue) rd_ptr <= rd_ptr + ADDR_W'(1);
         inflight <= issue;
         mem_cnt  <= mem_cnt + CNT_W'(push) - CNT_W'(issue);
      end
   end

   // Capture stage
   tp_fifo2_skid u_skid (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (inflight),
      .wr_data   (mem_data_out_b),
      .rd_en     (pop),
      .rd_data   (out_data),
      .occupancy (skid_occ)
   );

endmodule

// File: tb/tb_tp_mem_fifo_ctrl_16384_32.sv
// Bench for tp_mem_fifo_ctrl_16384_32: behavioural memory plus a queue reference of held words.
module tb_tp_mem_fifo_ctrl_16384_32;
   import tp_mem_fifo_ctrl_16384_32_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  count;
   logic              mem_wen_a;
   logic [ADDR_W-1:0] mem_addr_a;
   logic [DATA_W-1:0] mem_data_in_a;
   logic [ADDR_W-1:0] mem_addr_b;
   logic [DATA_W-1:0] mem_data_out_b;

   logic [DATA_W-1:0] mem [DEPTH];

   int                passed = 0;
   int                total  = 0;
   logic [DATA_W-1:0] q[$];
   int                push_cnt = 0;
   bit                hold_pend = 0;
   logic [DATA_W-1:0] hold_data;
   bit                saw_wrap_a = 0;
   bit                saw_wrap_b = 0;
   logic [ADDR_W-1:0] prev_b = '0;

   always #5 clk = ~clk;

   tp_mem_fifo_ctrl_16384_32 dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .count          (count),
      .mem_wen_a      (mem_wen_a),
      .mem_addr_a     (mem_addr_a),
      .mem_data_in_a  (mem_data_in_a),
      .mem_addr_b     (mem_addr_b),
      .mem_data_out_b (mem_data_out_b)
   );

   // Storage with a one-cycle registered read, as the real memory behaves.
   always @(posedge clk) begin
      if (mem_wen_a) mem[mem_addr_a] <= mem_data_in_a;
      mem_data_out_b <= mem[mem_addr_b];
   end

   always @(negedge clk) begin
      if (prev_b == ADDR_W'(DEPTH - 1) && mem_addr_b == '0) saw_wrap_b = 1'b1;
      prev_b = mem_addr_b;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      total++;
      assert (obs === want) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
   endtask

   // One clock: account for the transfers at the coming edge, then check count after it.
   task automatic cycle();
      logic [DATA_W-1:0] want;
      #1;
      if (hold_pend) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, hold_data);
         hold_pend = 0;
      end
      if (in_valid && in_ready) begin
         check("wr_en", mem_wen_a, 1);
         check("wr_addr", mem_addr_a, push_cnt % DEPTH);
         if (push_cnt > 0 && push_cnt % DEPTH == 0) saw_wrap_a = 1;
         push_cnt++;
         q.push_back(in_data);
      end
      if (out_valid && out_ready) begin
         check("pop_nonempty", q.size() != 0, 1);
         if (q.size() != 0) begin
            want = q.pop_front();
            check("rd_data", out_data, want);
         end
      end
      if (out_valid && !out_ready) begin
         hold_pend = 1;
         hold_data = out_data;
      end
      @(posedge clk);
      #1;
      check("count", count, q.size());
   endtask

   task automatic drain();
      int guard;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (q.size() != 0 && guard < 20000) begin
         cycle();
         guard++;
      end
      check("drain_empty", q.size(), 0);
      cycle();
      check("drain_out_valid", out_valid, 0);
   endtask

   initial begin
      int guard;
      int target;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;

      // Reset state, with a request present that must be ignored.
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_wen", mem_wen_a, 0);
      check("rst_addr_a", mem_addr_a, 0);
      check("rst_addr_b", mem_addr_b, 0);
      in_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("rel_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Single word, latency 2, count 1,1,1,0.
      in_valid  = 1'b1;
      in_data   = 32'hDEADBEEF;
      out_ready = 1'b1;
      #1;
      check("sw_wen", mem_wen_a, 1);
      check("sw_addr", mem_addr_a, 0);
      cycle();
      in_valid = 1'b0;
      check("sw_valid_t0", out_valid, 0);
      cycle();
      check("sw_valid_t1", out_valid, 0);
      cycle();
      check("sw_valid_t2", out_valid, 1);
      check("sw_data_t2", out_data, 32'hDEADBEEF);
      cycle();
      check("sw_valid_t3", out_valid, 0);
      check("sw_count_t3", count, 0);

      // Fill to DEPTH+2 with no reads accepted.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      guard = 0;
      while (in_ready && guard < 17000) begin
         in_data = $urandom;
         cycle();
         guard++;
      end
      check("fill_words", q.size(), DEPTH + 2);
      check("fill_count", count, DEPTH + 2);
      check("fill_in_ready", in_ready, 0);
      check("fill_out_valid", out_valid, 1);
      // A pop while full must not raise in_ready in the same cycle.
      out_ready = 1'b1;
      in_data   = $urandom;
      #1;
      check("full_pop_ready", in_ready, 0);
      cycle();
      check("after_pop_ready", in_ready, 1);
      drain();

      // Streaming at one word per cycle.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         in_data = 32'(i);
         #1;
         check("stream_ready", in_ready, 1);
         cycle();
         if (i >= 4) check("stream_count", (count == 2) || (count == 3), 1);
      end
      drain();

      // Backpressure at 30% out_ready duty.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = 1'b1;
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 9) < 3);
         cycle();
      end
      drain();

      // Long random run with periodic stalls.
      target = push_cnt + 20000;
      guard = 0;
      while (push_cnt < target && guard < 40000) begin
         in_valid  = ($urandom_range(0, 99) < 85);
         in_data   = $urandom;
         out_ready = ((guard % 37) < 30) && ($urandom_range(0, 9) < 9);
         cycle();
         guard++;
      end
      check("wrap_pushes", push_cnt >= target, 1);
      drain();
      check("wrap_a", saw_wrap_a, 1);
      check("wrap_b", saw_wrap_b, 1);

      // Reset in the middle of a burst.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      guard = 0;
      while (q.size() < 500 && guard < 1000) begin
         in_data = $urandom;
         cycle();
         guard++;
      end
      check("burst_count", count, 500);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_in_ready", in_ready, 0);
      q.delete();
      push_cnt  = 0;
      hold_pend = 0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      in_valid  = 1'b1;
      in_data   = 32'hCAFE0001;
      out_ready = 1'b1;
      #1;
      check("post_rst_addr", mem_addr_a, 0);
      cycle();
      in_valid = 1'b0;
      cycle();
      check("post_rst_valid_t1", out_valid, 0);
      cycle();
      check("post_rst_valid_t2", out_valid, 1);
      check("post_rst_data", out_data, 32'hCAFE0001);
      cycle();
      check("post_rst_empty", out_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
